// File: rtl/ldpc_min_row_sched_pkg.sv
// ==========================================================================
// ldpc_min_pkg : shared types and helpers for the LDPC min row scheduler
// Revision: 1.0
// ==========================================================================
`default_nettype none

package ldpc_min_pkg;

  localparam int LANES      = 8;
  localparam int TAG_BEAT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic [TAG_BEAT_W-1:0] beat;
    logic [LANES-1:0]      mask;
  } tag_t;

  function automatic logic [2:0] onehot_to_lane(input logic [LANES-1:0] loc);
    logic [2:0] lane;
    lane = 3'd0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (loc[k]) lane = 3'(k);
    end
    return lane;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ldpc_min_row_sched_if.sv
// ==========================================================================
// ldpc_min_row_sched_if : row, message, min-unit and result signals
// Revision: 1.0
// ==========================================================================
`default_nettype none

interface ldpc_min_row_sched_if #(
  parameter int WIDTH = 16,
  parameter int DEG_W = 6,
  parameter int IDX_W = 5
);
  logic               i_row_valid;
  logic               o_row_ready;
  logic [DEG_W-1:0]   i_row_degree;
  logic               i_msg_valid;
  logic               o_msg_ready;
  logic [8*WIDTH-1:0] i_msg_data;
  logic [8*WIDTH-1:0] o_min_in_data;
  logic [WIDTH-1:0]   i_min_out_data;
  logic [7:0]         i_min_location;
  logic               o_result_valid;
  logic               i_result_ready;
  logic [WIDTH-1:0]   o_result_min;
  logic [IDX_W-1:0]   o_result_index;
  logic               o_result_err;

  modport master (
    output i_row_valid, i_row_degree, i_msg_valid, i_msg_data,
           i_min_out_data, i_min_location, i_result_ready,
    input  o_row_ready, o_msg_ready, o_min_in_data, o_result_valid,
           o_result_min, o_result_index, o_result_err
  );

  modport slave (
    input  i_row_valid, i_row_degree, i_msg_valid, i_msg_data,
           i_min_out_data, i_min_location, i_result_ready,
    output o_row_ready, o_msg_ready, o_min_in_data, o_result_valid,
           o_result_min, o_result_index, o_result_err
  );
endinterface

`default_nettype wire

// File: rtl/ldpc_min_row_sched_tag_pipe.sv
// ==========================================================================
// ldpc_min_tag_pipe : shift register of in-flight beat tags
// Revision: 1.0
// ==========================================================================
`default_nettype none

module ldpc_min_tag_pipe
  import ldpc_min_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire  clk,
  input  wire  rst_n,
  input  tag_t push_tag,
  output tag_t out_tag,
  output logic any_valid
);

  tag_t stages [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= push_tag;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign out_tag = stages[DEPTH-1];

  // Only stages that will still be in flight after this edge count as busy.
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) any_valid = any_valid | stages[i].valid;
  end

endmodule

`default_nettype wire

// File: rtl/ldpc_min_row_sched.sv
// ==========================================================================
// ldpc_min_row_sched : streams one LDPC row through the 8-lane min unit
// Revision: 1.0
// ==========================================================================
`default_nettype none

module ldpc_min_row_sched
  import ldpc_min_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int MAX_DEGREE  = 32,
  parameter int MIN_LATENCY = 3,
  parameter int DEG_W       = 6,
  parameter int IDX_W       = 5
) (
  input wire i_clock,
  input wire i_reset_n,
  ldpc_min_row_sched_if.slave bus
);

  localparam int               CNT_W     = DEG_W - 3;
  localparam logic [DEG_W-1:0] MAX_DEG_C = DEG_W'(MAX_DEGREE);

  state_t           state;
  logic [DEG_W-1:0] degree;
  logic [CNT_W-1:0] beat;
  logic [CNT_W-1:0] last_beat;
  logic             row_err;
  logic [WIDTH-1:0] acc_min;
  logic [IDX_W-1:0] acc_idx;
  logic             acc_first;

  logic             deg_zero;
  logic             deg_over;
  logic [DEG_W-1:0] deg_eff;
  logic [DEG_W-1:0] deg_m1;

  assign deg_zero = (bus.i_row_degree == '0);
  assign deg_over = (bus.i_row_degree > MAX_DEG_C);
  assign deg_eff  = deg_over ? MAX_DEG_C : bus.i_row_degree;
  assign deg_m1   = deg_eff - DEG_W'(1);

  logic [DEG_W:0]       beat_base;
  logic [LANES-1:0]     lane_mask;
  logic [8*WIDTH-1:0]   masked_data;

  assign beat_base = {1'b0, beat, 3'b000};

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_mask[k] = (beat_base + (DEG_W+1)'(k)) < {1'b0, degree};
    assign masked_data[k*WIDTH +: WIDTH] =
      lane_mask[k] ? bus.i_msg_data[k*WIDTH +: WIDTH] : {WIDTH{1'b1}};
  end

  logic accept;
  tag_t push_tag;
  tag_t out_tag;
  logic pipe_busy;

  assign accept = (state == ST_ISSUE) && bus.i_msg_valid && bus.o_msg_ready;

  always_comb begin
    push_tag       = '0;
    push_tag.valid = accept;
    push_tag.beat  = TAG_BEAT_W'(beat);
    push_tag.mask  = lane_mask;
  end

  ldpc_min_tag_pipe #(
    .DEPTH (MIN_LATENCY + 1)
  ) u_tag_pipe (
    .clk       (i_clock),
    .rst_n     (i_reset_n),
    .push_tag  (push_tag),
    .out_tag   (out_tag),
    .any_valid (pipe_busy)
  );

  // A location that is empty, multi-hot or on a padded lane only occurs when
  // every live lane is all-ones, so lane 0 is as good an answer as any.
  logic [2:0]       raw_lane;
  logic [2:0]       lane;
  logic             lane_ok;
  logic             load;
  logic [IDX_W-1:0] cand_idx;
  logic [WIDTH-1:0] next_min;
  logic [IDX_W-1:0] next_idx;

  assign raw_lane = onehot_to_lane(bus.i_min_location);
  assign lane_ok  = $onehot(bus.i_min_location) && out_tag.mask[raw_lane];
  assign lane     = lane_ok ? raw_lane : 3'd0;
  assign cand_idx = IDX_W'({out_tag.beat, lane});
  assign load     = out_tag.valid && (acc_first || (bus.i_min_out_data < acc_min));
  assign next_min = load ? bus.i_min_out_data : acc_min;
  assign next_idx = load ? cand_idx : acc_idx;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state              <= ST_IDLE;
      degree             <= '0;
      beat               <= '0;
      last_beat          <= '0;
      row_err            <= 1'b0;
      acc_min            <= '1;
      acc_idx            <= '0;
      acc_first          <= 1'b1;
      bus.o_row_ready    <= 1'b1;
      bus.o_msg_ready    <= 1'b0;
      bus.o_min_in_data  <= '0;
      bus.o_result_valid <= 1'b0;
      bus.o_result_min   <= '0;
      bus.o_result_index <= '0;
      bus.o_result_err   <= 1'b0;
    end else begin
      if (out_tag.valid) begin
        acc_min   <= next_min;
        acc_idx   <= next_idx;
        acc_first <= 1'b0;
      end
      if (accept) bus.o_min_in_data <= masked_data;

      case (state)
        ST_IDLE: begin
          if (bus.i_row_valid) begin
            bus.o_row_ready <= 1'b0;
            degree          <= deg_eff;
            beat            <= '0;
            last_beat       <= CNT_W'(deg_m1 >> 3);
            row_err         <= deg_zero || deg_over;
            if (deg_zero) begin
              state              <= ST_DONE;
              bus.o_result_valid <= 1'b1;
              bus.o_result_min   <= '1;
              bus.o_result_index <= '0;
              bus.o_result_err   <= 1'b1;
            end else begin
              state           <= ST_ISSUE;
              bus.o_msg_ready <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (accept) begin
            beat <= beat + CNT_W'(1);
            if (beat == last_beat) begin
              state           <= ST_DRAIN;
              bus.o_msg_ready <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          // The final tag is folded on this same edge via next_min/next_idx.
          if (!pipe_busy) begin
            state              <= ST_DONE;
            bus.o_result_valid <= 1'b1;
            bus.o_result_min   <= next_min;
            bus.o_result_index <= next_idx;
            bus.o_result_err   <= row_err;
          end
        end
        ST_DONE: begin
          if (bus.i_result_ready) begin
            state              <= ST_IDLE;
            bus.o_result_valid <= 1'b0;
            bus.o_row_ready    <= 1'b1;
            acc_min            <= '1;
            acc_idx            <= '0;
            acc_first          <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ldpc_min_row_sched.sv
// ==========================================================================
// tb_ldpc_min_row_sched : directed bench with row-level reference model
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_ldpc_min_row_sched;

  localparam int WIDTH = 16;
  localparam int DEG_W = 6;
  localparam int IDX_W = 5;
  localparam int MAXD  = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ldpc_min_row_sched_if #(.WIDTH(WIDTH), .DEG_W(DEG_W), .IDX_W(IDX_W)) bus ();

  ldpc_min_row_sched #(
    .WIDTH       (WIDTH),
    .MAX_DEGREE  (MAXD),
    .MIN_LATENCY (3),
    .DEG_W       (DEG_W),
    .IDX_W       (IDX_W)
  ) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  // External 8-input, 3-cycle min unit; lowest lane wins ties, never reset.
  logic [WIDTH-1:0] mu_v [3];
  logic [7:0]       mu_l [3];
  logic             force_loc7 = 1'b0;
  logic [WIDTH-1:0] mu_m;
  logic [7:0]       mu_h;

  always @(posedge clk) begin
    mu_m = bus.o_min_in_data[WIDTH-1:0];
    mu_h = 8'h01;
    for (int k = 1; k < 8; k++) begin
      if (bus.o_min_in_data[k*WIDTH +: WIDTH] < mu_m) begin
        mu_m = bus.o_min_in_data[k*WIDTH +: WIDTH];
        mu_h = 8'(1 << k);
      end
    end
    mu_v[0] <= mu_m;    mu_l[0] <= mu_h;
    mu_v[1] <= mu_v[0]; mu_l[1] <= mu_l[0];
    mu_v[2] <= mu_v[1]; mu_l[2] <= mu_l[1];
  end

  assign bus.i_min_out_data = mu_v[2];
  assign bus.i_min_location = force_loc7 ? 8'h80 : mu_l[2];

  int               checks = 0;
  int               errors = 0;
  logic [15:0]      msgs [40];
  logic [15:0]      t1 [8] = '{16'd9, 16'd7, 16'd5, 16'd3, 16'd11, 16'd2, 16'd8, 16'd6};
  logic [15:0]      t6 [8] = '{16'd120, 16'd110, 16'd105, 16'd130, 16'd140, 16'd150, 16'd160, 16'd170};
  logic [WIDTH-1:0] exp_min;
  logic [IDX_W-1:0] exp_idx;
  logic             exp_err;
  logic             armed = 1'b0;
  logic [127:0]     last_min_in;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Row-level reference: smallest value among the first min(D,MAX) messages,
  // earliest index on ties; degree 0 yields all-ones with the error flag.
  task automatic model(input int deg);
    int d;
    d = (deg > MAXD) ? MAXD : deg;
    if (deg == 0) begin
      exp_min = '1; exp_idx = '0; exp_err = 1'b1;
    end else begin
      exp_min = msgs[0]; exp_idx = '0;
      for (int i = 1; i < d; i++) begin
        if (msgs[i] < exp_min) begin
          exp_min = msgs[i];
          exp_idx = IDX_W'(i);
        end
      end
      exp_err = (deg > MAXD);
    end
  endtask

  always @(negedge clk) begin
    if (armed && bus.o_result_valid) begin
      chk("result_min", bus.o_result_min, exp_min);
      chk("result_index", bus.o_result_index, exp_idx);
      chk("result_err", bus.o_result_err, exp_err);
      chk("row_ready_while_done", bus.o_row_ready, 0);
    end
  end

  task automatic load_beat(input int b);
    for (int k = 0; k < 8; k++) bus.i_msg_data[k*16 +: 16] = msgs[b*8 + k];
  endtask

  task automatic run_row(input int deg, input int gap, input int hold, input int exp_lat,
                         input logic [15:0] lit_min, input int lit_idx, input logic lit_err);
    int           n;
    int           d;
    int           nbeats;
    longint       r_t;
    logic [127:0] expd;
    model(deg);
    armed  = 1'b1;
    d      = (deg > MAXD) ? MAXD : deg;
    nbeats = (d + 7) / 8;
    bus.i_row_valid  = 1'b1;
    bus.i_row_degree = DEG_W'(deg);
    n = 0;
    while (!bus.o_row_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("row_ready", bus.o_row_ready, 1);
    @(posedge clk); r_t = longint'($time); #1;
    bus.i_row_valid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (b > 0) repeat (gap) begin bus.i_msg_valid = 1'b0; @(posedge clk); #1; end
      load_beat(b);
      bus.i_msg_valid = 1'b1;
      n = 0;
      while (!bus.o_msg_ready && n < 50) begin @(posedge clk); #1; n++; end
      chk("msg_ready", bus.o_msg_ready, 1);
      @(posedge clk); #1;
      for (int k = 0; k < 8; k++) expd[k*16 +: 16] = (b*8 + k < d) ? msgs[b*8 + k] : 16'hFFFF;
      chk("min_in_data", bus.o_min_in_data, expd);
      last_min_in = bus.o_min_in_data;
    end
    bus.i_msg_valid = 1'b0;
    n = 0;
    while (!bus.o_result_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("result_valid", bus.o_result_valid, 1);
    chk("latency", (longint'($time) - 1 - r_t) / 10, exp_lat);
    chk("lit_min", bus.o_result_min, lit_min);
    chk("lit_index", bus.o_result_index, lit_idx);
    chk("lit_err", bus.o_result_err, lit_err);
    repeat (hold) begin @(posedge clk); #1; end
    bus.i_result_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_result_ready = 1'b0;
    armed = 1'b0;
    chk("valid_dropped", bus.o_result_valid, 0);
    chk("row_ready_back", bus.o_row_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_row_ready"}, bus.o_row_ready, 1);
    chk({tag, "_msg_ready"}, bus.o_msg_ready, 0);
    chk({tag, "_min_in"}, bus.o_min_in_data, 0);
    chk({tag, "_valid"}, bus.o_result_valid, 0);
    chk({tag, "_min"}, bus.o_result_min, 0);
    chk({tag, "_index"}, bus.o_result_index, 0);
    chk({tag, "_err"}, bus.o_result_err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bus.i_row_valid    = 1'b0;
    bus.i_row_degree   = '0;
    bus.i_msg_valid    = 1'b0;
    bus.i_msg_data     = '0;
    bus.i_result_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single beat, no stalls
    for (int i = 0; i < 40; i++) msgs[i] = (i < 8) ? t1[i] : 16'd0;
    run_row(8, 0, 0, 5, 16'd2, 5, 1'b0);

    // Partial last beat: padding must hide the zeros beyond degree 20
    for (int i = 0; i < 40; i++) msgs[i] = (i < 20) ? 16'(50 + i) : 16'd0;
    msgs[17] = 16'd1;
    run_row(20, 0, 0, 7, 16'd1, 17, 1'b0);
    chk("beat2_pad_lanes", last_min_in[127:64], {4{16'hFFFF}});

    // Tie across beats, then the same row with two bubbles between beats
    for (int i = 0; i < 40; i++) msgs[i] = 16'd9;
    msgs[2] = 16'd4; msgs[12] = 16'd4;
    run_row(16, 0, 0, 6, 16'd4, 2, 1'b0);
    run_row(16, 2, 0, 8, 16'd4, 2, 1'b0);

    // All-ones with a bogus location on a padded lane
    for (int i = 0; i < 40; i++) msgs[i] = 16'hFFFF;
    force_loc7 = 1'b1;
    run_row(3, 0, 0, 5, 16'hFFFF, 0, 1'b0);
    force_loc7 = 1'b0;

    // Degree 0 and degree above the maximum
    run_row(0, 0, 0, 0, 16'hFFFF, 0, 1'b1);
    for (int i = 0; i < 40; i++) msgs[i] = 16'(1000 - i);
    msgs[31] = 16'd3; msgs[35] = 16'd0;
    run_row(40, 0, 0, 8, 16'd3, 31, 1'b1);

    // Result held under back-pressure for 10 cycles
    for (int i = 0; i < 40; i++) msgs[i] = (i < 8) ? t6[i] : 16'd0;
    run_row(8, 0, 10, 5, 16'd105, 2, 1'b0);

    // Reset during the second beat of a row whose first beat carries a zero
    for (int i = 0; i < 40; i++) msgs[i] = (i == 1) ? 16'd0 : 16'd500;
    bus.i_row_valid  = 1'b1;
    bus.i_row_degree = 6'd16;
    n = 0;
    while (!bus.o_row_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.i_row_valid = 1'b0;
    load_beat(0);
    bus.i_msg_valid = 1'b1;
    @(posedge clk); #1;
    load_beat(1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrow");
    @(posedge clk); #1;
    bus.i_msg_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) msgs[i] = (i < 8) ? t6[i] : 16'd0;
    run_row(8, 0, 0, 5, 16'd105, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
